// File: rtl/instr_mem_responder.sv
// Instruction memory responder: fixed-latency fetch pipeline feeding a 4-entry in-order response FIFO.
// Optional fetch-error reporting is enabled by defining IMEM_FETCH_ERR_EN.
module instr_mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  logic [31:0] mem [DEPTH];

  logic [29:0] req_idx;
  logic [29:0] ld_idx;
  logic        req_in_range;
  logic        ld_in_range;
  logic [31:0] read_data;
  logic        accept;
  logic        push;
  logic        pop;
  logic        unused_bits;

  logic [LATENCY-1:0] pipe_vld;
  logic [31:0]        pipe_instr [LATENCY];
  logic [31:0]        fifo_instr [FIFO_DEPTH];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [2:0]         fifo_count;
  logic [2:0]         inflight;

  assign req_idx      = req_addr[31:2];
  assign ld_idx       = ld_addr[31:2];
  assign req_in_range = 32'(req_idx) < 32'(DEPTH);
  assign ld_in_range  = 32'(ld_idx) < 32'(DEPTH);
  assign read_data    = req_in_range ? mem[req_idx[AW-1:0]] : NOP_INSTR;
  assign unused_bits  = ^{req_addr[1:0], ld_addr[1:0]};

  // Slots are reserved at acceptance, so a same-cycle pop never frees room for a new request.
  assign req_ready = reset && (({1'b0, inflight} + {1'b0, fifo_count}) != 4'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = pipe_vld[LATENCY-1];
  assign rsp_valid = (fifo_count != 3'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_instr = rsp_valid ? fifo_instr[rd_ptr] : 32'h0;

  // Memory, read pipeline and FIFO payload; memory survives reset. The read above sees pre-write data.
  always_ff @(posedge clock) begin
    if (ld_en && ld_in_range) begin
      mem[ld_idx[AW-1:0]] <= ld_data;
    end
    pipe_instr[0] <= read_data;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_instr[k] <= pipe_instr[k-1];
    end
    if (push) begin
      fifo_instr[wr_ptr] <= pipe_instr[LATENCY-1];
    end
  end

  // Control state: pipeline valids, in-flight count, FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_vld   <= '0;
      inflight   <= 3'd0;
      fifo_count <= 3'd0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
    end else begin
      pipe_vld[0] <= accept;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
      end
      inflight   <= inflight + 3'(accept) - 3'(push);
      fifo_count <= fifo_count + 3'(push) - 3'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
    end
  end

`ifdef IMEM_FETCH_ERR_EN
  logic                req_err;
  logic [LATENCY-1:0]  pipe_err;
  logic [FIFO_DEPTH-1:0] fifo_err;

  assign req_err = (req_addr[1:0] != 2'b00) || !req_in_range;
  assign rsp_err = rsp_valid && fifo_err[rd_ptr];

  // Error flag travels alongside the instruction word.
  always_ff @(posedge clock) begin
    pipe_err[0] <= req_err;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_err[k] <= pipe_err[k-1];
    end
    if (push) begin
      fifo_err[wr_ptr] <= pipe_err[LATENCY-1];
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: queue-based reference model plus directed literal checks.
// Honours IMEM_FETCH_ERR_EN the same way the design does.
module tb_instr_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_FETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a response is a record counting down LAT edges, then waits in an output queue.
  typedef struct {
    int          rem;
    logic [31:0] ins;
    logic        err;
  } ent_t;

  ent_t        pipe_q[$];
  ent_t        fifo_q[$];
  logic [31:0] mmem [DEPTH];
  bit          m_acc;
  bit          m_pop;
  int unsigned m_idx;
  int unsigned m_ld;
  ent_t        m_new;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_q.delete();
      fifo_q.delete();
    end else begin
      m_acc = req_valid && ((pipe_q.size() + fifo_q.size()) < 4);
      m_pop = rsp_ready && (fifo_q.size() > 0);
      m_idx = int'(req_addr[31:2]);
      m_new.rem = LAT;
      m_new.ins = (m_idx < DEPTH) ? mmem[m_idx] : NOP;
      m_new.err = ERR_EN && ((req_addr[1:0] != 2'b00) || (m_idx >= DEPTH));
      if (m_pop) void'(fifo_q.pop_front());
      for (int i = 0; i < pipe_q.size(); i++) pipe_q[i].rem = pipe_q[i].rem - 1;
      while (pipe_q.size() > 0 && pipe_q[0].rem == 0) fifo_q.push_back(pipe_q.pop_front());
      if (m_acc) pipe_q.push_back(m_new);
      m_ld = int'(ld_addr[31:2]);
      if (ld_en && m_ld < DEPTH) mmem[m_ld] = ld_data;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("mdl_req_ready", 32'(req_ready), 32'(reset && ((pipe_q.size() + fifo_q.size()) < 4)));
    check("mdl_rsp_valid", 32'(rsp_valid), 32'(fifo_q.size() > 0));
    if (rsp_valid && fifo_q.size() > 0) begin
      check("mdl_rsp_instr", rsp_instr, fifo_q[0].ins);
      check("mdl_rsp_err", 32'(rsp_err), 32'(fifo_q[0].err));
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clock); #1;
    ld_en = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] ins, output logic err);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
    ins = rsp_instr;
    err = rsp_err;
    @(posedge clock); #1;
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] ins, output logic err);
    req_valid = 1'b1; req_addr = a;
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_rsp(ins, err);
  endtask

  logic [31:0] ins;
  logic        err;
  logic [31:0] exp4 [4];
  int          stale;
  logic [31:0] bp_pat;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    exp4[0] = 32'h0050_0093; exp4[1] = 32'hA000_0001;
    exp4[2] = 32'hA000_0002; exp4[3] = 32'hA000_0003;
    bp_pat  = 32'b1011_0010_1110_0001_0100_1101_1000_1011;

    repeat (2) @(negedge clock);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_instr", rsp_instr, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    #2 reset = 1'b1;
    #1 check("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;

    for (int i = 0; i < DEPTH; i++) do_load(32'(i * 4), 32'hA000_0000 | 32'(i));

    // Single fetch: response visible exactly LAT edges after acceptance.
    do_load(32'h0, 32'h0050_0093);
    req_valid = 1'b1; req_addr = 32'h0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock); check("lat_edge1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clock); check("lat_edge2_valid", 32'(rsp_valid), 32'd0);
    @(negedge clock); check("lat_edge3_valid", 32'(rsp_valid), 32'd1);
    check("lat_instr", rsp_instr, 32'h0050_0093);
    @(posedge clock); #1;

    // Four back-to-back requests under backpressure fill all slots, then drain in order.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_addr = 32'(k * 4);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    @(negedge clock); check("full_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    check("full_head_instr", rsp_instr, exp4[0]);
    check("full_still_busy", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("drain_valid", 32'(rsp_valid), 32'd1);
      check("drain_instr", rsp_instr, exp4[k]);
    end
    @(negedge clock); check("drain_empty", 32'(rsp_valid), 32'd0);
    @(posedge clock); #1;

    // Out-of-range fetch returns NOP.
    fetch(32'h100, ins, err);
    check("oor_instr", ins, NOP);
    check("oor_err", 32'(err), 32'(ERR_EN));
    // Misaligned fetch returns the containing word.
    fetch(32'h6, ins, err);
    check("misal_instr", ins, 32'hA000_0001);
    check("misal_err", 32'(err), 32'(ERR_EN));
    fetch(32'h4, ins, err);
    check("aligned_err", 32'(err), 32'd0);
    // Out-of-range load is dropped and does not alias word 0.
    do_load(32'h100, 32'h1234_5678);
    fetch(32'h100, ins, err);
    check("oor_load_dropped", ins, NOP);
    fetch(32'h0, ins, err);
    check("no_alias_word0", ins, 32'h0050_0093);

    // Same-cycle load and fetch of one word returns the old data.
    ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 32'h8;
    @(posedge clock); #1;
    ld_en = 1'b0; req_valid = 1'b0;
    wait_rsp(ins, err);
    check("rw_same_old", ins, 32'hA000_0002);
    fetch(32'h8, ins, err);
    check("rw_after_new", ins, 32'hDEAD_BEEF);

    // Streaming with rsp_ready held: one acceptance per cycle.
    for (int k = 0; k < 12; k++) begin
      req_valid = 1'b1; req_addr = 32'((k % 5) * 4);
      @(negedge clock); check("stream_ready", 32'(req_ready), 32'd1);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    repeat (6) begin @(posedge clock); #1; end

    // Streaming under a fixed backpressure pattern, mixed addresses.
    for (int k = 0; k < 32; k++) begin
      req_valid = 1'b1;
      req_addr  = (k % 7 == 3) ? 32'h102 : 32'((k * 12) % 256);
      rsp_ready = bp_pat[k];
      @(posedge clock); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) begin @(posedge clock); #1; end

    // Reset with one response queued and two in flight.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_addr = 32'(k * 4);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    check("async_rst_instr", rsp_instr, 32'h0);
    @(posedge clock); @(posedge clock); #3;
    reset = 1'b1;
    #1 check("rel_rst_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (rsp_valid) stale++;
    end
    check("no_stale_rsp", 32'(stale), 32'd0);
    @(posedge clock); #1;
    fetch(32'h4, ins, err);
    check("mem_survives_rst", ins, 32'hA000_0001);
    fetch(32'h8, ins, err);
    check("mem_survives_rst2", ins, 32'hDEAD_BEEF);

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the instruction memory size in 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to response valid; legal values are 1 to 4.
REQ-003 The block SHALL have port clock, input, 1 bit, the system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit, meaning a fetch request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit, meaning the responder can accept a request.
REQ-007 The block SHALL have port req_addr, input, 32 bits, the byte address of the fetch (the PC).
REQ-008 The block SHALL have port rsp_valid, output, 1 bit, meaning a response is present.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit, meaning the fetch side consumes the response.
REQ-010 The block SHALL have port rsp_instr, output, 32 bits, the returned instruction code.
REQ-011 The block SHALL have port rsp_err, output, 1 bit, the fetch error flag.
REQ-012 The block SHALL have port ld_en, input, 1 bit, the program-load write strobe.
REQ-013 The block SHALL have port ld_addr, input, 32 bits, the program-load byte address; bits [1:0] are ignored.
REQ-014 The block SHALL have port ld_data, input, 32 bits, the program-load word.

Function
REQ-015 A request SHALL be accepted in any cycle where req_valid and req_ready are both 1 at the rising edge.
REQ-016 On acceptance, the word index SHALL be req_addr[31:2], and memory SHALL be read in that same cycle.
REQ-017 A response SHALL enter the 4-entry in-order response FIFO exactly LATENCY cycles after acceptance.
REQ-018 rsp_valid SHALL be 1 whenever the FIFO is non-empty; rsp_instr and rsp_err SHALL show the head entry.
REQ-019 A response SHALL be popped when rsp_valid and rsp_ready are both 1; rsp_instr and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-020 req_ready SHALL be 0 when (in-flight count + FIFO occupancy) equals 4, and 1 otherwise.
REQ-021 A pop in the same cycle SHALL NOT free a slot for a same-cycle acceptance; req_ready is computed from registered counts only.
REQ-022 Responses SHALL be returned in acceptance order, with back-to-back acceptance sustained at 1 per cycle while rsp_ready=1.
REQ-023 When ld_en=1, the edge SHALL write ld_data to word ld_addr[31:2] if that index is less than DEPTH; otherwise the write SHALL be dropped silently.
REQ-024 When a load and an accepted request hit the same word in the same cycle, the response SHALL return the pre-write data.
REQ-025 A request with word index >= DEPTH SHALL return rsp_instr=32'h00000013 (the NOP instruction).
REQ-026 The in-flight counter and FIFO pointers SHALL wrap modulo their sizes, and no response SHALL be lost or duplicated.

Reset
REQ-027 While reset=0: rsp_valid=0, rsp_instr=0, rsp_err=0, req_ready=0, the FIFO is empty, and the in-flight pipeline is cleared.
REQ-028 Requests in flight when reset asserts SHALL be discarded and never returned.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 With macro IMEM_FETCH_ERR_EN defined, rsp_err=1 SHALL be set for any response whose req_addr[1:0]!=0 or whose word index >= DEPTH.
REQ-032 With IMEM_FETCH_ERR_EN defined, a misaligned in-range request SHALL still return the word at req_addr[31:2].
REQ-033 Without IMEM_FETCH_ERR_EN, rsp_err SHALL be tied to 0 and no error state SHALL be stored in the FIFO.

Verification
REQ-034 Load 32'h00500093 at address 0x0, then request 0x0 with LATENCY=2 and rsp_ready=1 -> rsp_valid=1 exactly 2 cycles after acceptance, with rsp_instr=32'h00500093.
REQ-035 Request 0x0, 0x4, 0x8, 0xC back-to-back with rsp_ready=0 -> all 4 accepted, req_ready=0 after the 4th, FIFO holds 4 entries; raise rsp_ready -> 4 in-order responses on 4 consecutive cycles.
REQ-036 Request 0x100 with DEPTH=64 -> rsp_instr=32'h00000013, and rsp_err=1 only with IMEM_FETCH_ERR_EN.
REQ-037 Request 0x6 -> returns word 1, and rsp_err=1 with IMEM_FETCH_ERR_EN, 0 without.
REQ-038 Load 0xDEADBEEF to 0x8 in the same cycle as a request to 0x8 -> the response is the old word; the next request to 0x8 returns 0xDEADBEEF.
REQ-039 Assert reset with 2 requests in flight -> rsp_valid=0 immediately, no stale response after release, and req_ready=1 on the first post-reset cycle.
